tof_cal_multi: RTL and testbench

Parametrised multi-hit TDC time-of-flight calculator. It accepts thermometer-coded fine samples plus coarse counter values for one start hit and up to NUM_HIT stop hits per shot. A fully pipelined priority encoder accepts one sample per cycle. Each stop produces a range-checked TOF that is buffered in a small result FIFO with a valid/ready output handshake.

---
 rtl/tof_cal_multi.sv | 208 ++++++++++++++++++++
 tb/tb_tof_cal_multi.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/tof_cal_multi.sv
// Multi-hit TDC time-of-flight calculator: pipelined thermometer encoder, per-shot stop
// indexing with range check, and a small result FIFO. Define TOF_STAT_EN for hit/drop counters.
module tof_cal_multi #(
  parameter  int unsigned TAP_W      = 32,
  parameter  int unsigned CNT_W      = 10,
  parameter  int unsigned NUM_HIT    = 4,
  parameter  int unsigned FIFO_DEPTH = 4,
  localparam int unsigned FINE_W     = $clog2(TAP_W),
  localparam int unsigned TOF_W      = CNT_W + FINE_W,
  localparam int unsigned IDX_W      = $clog2(NUM_HIT)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cal_en,
  input  logic               sample_vld,
  input  logic               sample_start,
  input  logic [TAP_W-1:0]   decode_in,
  input  logic [CNT_W-1:0]   counter_in,
  input  logic [TOF_W-1:0]   range,
  output logic               dec_valid,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [TOF_W-1:0]   tof_data,
  output logic [IDX_W-1:0]   tof_idx,
  output logic               tof_ovr,
  output logic               drop,
  output logic               busy
`ifdef TOF_STAT_EN
  ,
  output logic [15:0]        stat_hits,
  output logic [15:0]        stat_drops
`endif
);
  localparam int unsigned HALF = TAP_W / 2;
  localparam int unsigned NST  = FINE_W - 1;
  localparam int unsigned HC_W = IDX_W + 1;
  localparam int unsigned PW   = $clog2(FIFO_DEPTH);
  localparam logic [HALF-1:0]   ONES     = '1;
  localparam logic [FINE_W-1:0] FONE     = 1;
  localparam logic [HC_W-1:0]   LAST_HIT = HC_W'(NUM_HIT - 1);
  localparam logic [PW:0]       CNT_ONE  = 1;
  localparam logic [PW:0]       FULL_CNT = (PW + 1)'(FIFO_DEPTH);
  localparam logic [PW-1:0]     PTR_ONE  = 1;

  // Encoder pipeline
  logic              acc;
  logic [TAP_W-1:0]  norbuf;
  logic [NST-1:0]    vld_q, st_q;
  logic [CNT_W-1:0]  cn_q [NST];
  logic [HALF-1:0]   nb_q [NST];
  logic [HALF-1:0]   nb_d [NST];
  logic [FINE_W-1:0] fn_q [NST];
  logic [FINE_W-1:0] fn_d [NST];
  logic [HALF-1:0]   mask, upper;
  logic              dec_st;
  logic [CNT_W-1:0]  dec_cnt;
  logic [FINE_W-1:0] dec_fine;

  assign acc    = sample_vld & cal_en;
  assign norbuf = decode_in ^ {decode_in[0], decode_in[TAP_W-1:1]};

  // Each stage halves the live window; nb_q[k] keeps only the surviving half, high bits zero.
  always_comb begin
    mask    = '0;
    upper   = '0;
    nb_d[0] = norbuf[HALF-1:0];
    fn_d[0] = {decode_in[HALF], {(FINE_W-1){1'b0}}};
    for (int unsigned k = 1; k < NST; k++) begin
      mask  = ONES >> (HALF - (TAP_W >> (k + 1)));
      upper = (nb_q[k-1] >> (TAP_W >> (k + 1))) & mask;
      if (upper == '0) begin
        nb_d[k] = nb_q[k-1] & mask;
        fn_d[k] = fn_q[k-1] | (FONE << (FINE_W - 1 - k));
      end else begin
        nb_d[k] = upper;
        fn_d[k] = fn_q[k-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q     <= '0;
      dec_valid <= 1'b0;
    end else begin
      vld_q     <= {vld_q[NST-2:0], acc};
      dec_valid <= vld_q[NST-1];
    end
    st_q     <= {st_q[NST-2:0], sample_start};
    nb_q     <= nb_d;
    fn_q     <= fn_d;
    cn_q[0]  <= counter_in;
    for (int unsigned k = 1; k < NST; k++) cn_q[k] <= cn_q[k-1];
    dec_st   <= st_q[NST-1];
    dec_cnt  <= cn_q[NST-1];
    dec_fine <= fn_q[NST-1] | {{(FINE_W-1){1'b0}}, ~nb_q[NST-1][1]};
  end

  // Shot tracking and TOF compute
  logic              start_valid;
  logic [HC_W-1:0]   hit_cnt;
  logic [TOF_W-1:0]  stamp_s, dec_stamp, diff;
  logic              orphan;
  logic              cmp_vld, cmp_ovr, wr_vld, wr_ovr;
  logic [TOF_W-1:0]  cmp_data, wr_data;
  logic [IDX_W-1:0]  cmp_idx, wr_idx;

  assign dec_stamp = {dec_cnt, dec_fine};
  assign diff      = dec_stamp - stamp_s;
  assign orphan    = dec_valid & ~dec_st & ~start_valid;

  always_ff @(posedge clk) begin
    if (rst) begin
      start_valid <= 1'b0;
      hit_cnt     <= '0;
      stamp_s     <= '0;
      cmp_vld     <= 1'b0;
      wr_vld      <= 1'b0;
    end else begin
      cmp_vld <= 1'b0;
      wr_vld  <= cmp_vld;
      if (dec_valid && dec_st) begin
        stamp_s     <= dec_stamp;
        start_valid <= 1'b1;
        hit_cnt     <= '0;
      end else if (dec_valid && start_valid) begin
        cmp_vld <= 1'b1;
        hit_cnt <= hit_cnt + 1'b1;
        if (hit_cnt == LAST_HIT) start_valid <= 1'b0;
      end
    end
    cmp_idx  <= hit_cnt[IDX_W-1:0];
    cmp_data <= (diff <= range) ? diff : '1;
    cmp_ovr  <= (diff > range);
    wr_idx   <= cmp_idx;
    wr_data  <= cmp_data;
    wr_ovr   <= cmp_ovr;
  end

  // Result FIFO
  logic [TOF_W-1:0]      mem_data [FIFO_DEPTH];
  logic [IDX_W-1:0]      mem_idx  [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0] mem_ovr;
  logic [PW-1:0]         wr_ptr, rd_ptr;
  logic [PW:0]           count, count_nxt;
  logic                  pop, full, do_push;

  assign pop     = out_valid & out_ready;
  assign full    = (count == FULL_CNT);
  assign do_push = wr_vld & (~full | pop);

  always_comb begin
    count_nxt = count;
    if (do_push && !pop)      count_nxt = count + CNT_ONE;
    else if (!do_push && pop) count_nxt = count - CNT_ONE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      out_valid <= 1'b0;
      drop      <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)     rd_ptr <= rd_ptr + PTR_ONE;
      count     <= count_nxt;
      out_valid <= (count_nxt != '0);
      drop      <= drop | (wr_vld & ~do_push);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_data[wr_ptr] <= wr_data;
      mem_idx[wr_ptr]  <= wr_idx;
      mem_ovr[wr_ptr]  <= wr_ovr;
    end
  end

  assign tof_data = out_valid ? mem_data[rd_ptr] : '0;
  assign tof_idx  = out_valid ? mem_idx[rd_ptr]  : '0;
  assign tof_ovr  = out_valid & mem_ovr[rd_ptr];
  assign busy     = start_valid | (|vld_q) | dec_valid | cmp_vld | wr_vld;

`ifdef TOF_STAT_EN
  logic [1:0]  drop_inc;
  logic [16:0] drop_sum;

  assign drop_inc = {1'b0, wr_vld & ~do_push} + {1'b0, orphan};
  assign drop_sum = {1'b0, stat_drops} + {15'd0, drop_inc};

  always_ff @(posedge clk) begin
    if (rst) begin
      stat_hits  <= '0;
      stat_drops <= '0;
    end else begin
      if (do_push && stat_hits != '1) stat_hits <= stat_hits + 16'd1;
      stat_drops <= drop_sum[16] ? '1 : drop_sum[15:0];
    end
  end
`else
  logic unused_orphan;
  assign unused_orphan = orphan;
`endif

endmodule

// File: tb/tb_tof_cal_multi.sv
// Directed bench for tof_cal_multi (TAP_W=32, CNT_W=10, NUM_HIT=4, FIFO_DEPTH=4).
module tb_tof_cal_multi;
  logic        clk = 1'b0;
  logic        rst, cal_en, sample_vld, sample_start, out_ready;
  logic [31:0] decode_in;
  logic [9:0]  counter_in;
  logic [14:0] range, tof_data;
  logic [1:0]  tof_idx;
  logic        dec_valid, out_valid, tof_ovr, drop, busy;
`ifdef TOF_STAT_EN
  logic [15:0] stat_hits, stat_drops;
`endif
  int n_cmp = 0;
  int n_err = 0;

  tof_cal_multi #(.TAP_W(32), .CNT_W(10), .NUM_HIT(4), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst(rst), .cal_en(cal_en), .sample_vld(sample_vld),
    .sample_start(sample_start), .decode_in(decode_in), .counter_in(counter_in),
    .range(range), .dec_valid(dec_valid), .out_valid(out_valid), .out_ready(out_ready),
    .tof_data(tof_data), .tof_idx(tof_idx), .tof_ovr(tof_ovr), .drop(drop), .busy(busy)
`ifdef TOF_STAT_EN
    , .stat_hits(stat_hits), .stat_drops(stat_drops)
`endif
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic hit(input logic st, input logic [9:0] cn, input logic [31:0] code);
    sample_vld   = 1'b1;
    sample_start = st;
    counter_in   = cn;
    decode_in    = code;
    step();
    sample_vld   = 1'b0;
    sample_start = 1'b0;
  endtask

  task automatic pop_chk(input string tag, input logic [14:0] d, input logic [1:0] idx,
                         input logic ovr);
    chk({tag, "_valid"}, out_valid, 1);
    chk({tag, "_data"}, tof_data, d);
    chk({tag, "_idx"}, tof_idx, idx);
    chk({tag, "_ovr"}, tof_ovr, ovr);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  initial begin
    rst = 1'b1; cal_en = 1'b0; sample_vld = 1'b0; sample_start = 1'b0;
    out_ready = 1'b0; decode_in = '0; counter_in = '0; range = 15'd1000;
    repeat (2) step();
    rst = 1'b0;
    chk("rst_dec_valid", dec_valid, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_tof_data", tof_data, 0);
    chk("rst_tof_idx", tof_idx, 0);
    chk("rst_tof_ovr", tof_ovr, 0);
    chk("rst_drop", drop, 0);
    chk("rst_busy", busy, 0);

    // Encoder latency with back-to-back accepts (orphan stops, never written)
    cal_en = 1'b1;
    hit(1'b0, 10'd0, 32'h0000_00FF);
    hit(1'b0, 10'd0, 32'h0000_000F);
    for (int i = 2; i <= 7; i++) begin
      step();
      chk($sformatf("dec_valid_t%0d", i), dec_valid, (i == 4 || i == 5) ? 1 : 0);
    end
    chk("orphan_no_write", out_valid, 0);

    // cal_en low blocks acceptance
    cal_en = 1'b0;
    hit(1'b0, 10'd0, 32'h0000_000F);
    repeat (4) step();
    chk("cal_en_gate", dec_valid, 0);
    cal_en = 1'b1;

    // Basic measurement: 296 - 172 = 124
    range = 15'd1000;
    hit(1'b1, 10'd5, 32'h0000_000F);
    hit(1'b0, 10'd9, 32'h0000_00FF);
    repeat (6) step();
    chk("basic_lat6", out_valid, 0);
    step();
    chk("basic_lat7", out_valid, 1);
    pop_chk("basic", 15'd124, 2'd0, 1'b0);
    chk("basic_empty", out_valid, 0);

    // Over range
    range = 15'd100;
    hit(1'b1, 10'd5, 32'h0000_000F);
    hit(1'b0, 10'd9, 32'h0000_00FF);
    repeat (7) step();
    pop_chk("ovr", 15'h7FFF, 2'd0, 1'b1);

    // Coarse wrap: 72 - 32652 mod 2^15 = 188, with range exactly at and just below
    range = 15'd188;
    hit(1'b1, 10'd1020, 32'h0000_000F);
    hit(1'b0, 10'd2, 32'h0000_00FF);
    repeat (7) step();
    pop_chk("wrap_eq", 15'd188, 2'd0, 1'b0);
    range = 15'd187;
    hit(1'b1, 10'd1020, 32'h0000_000F);
    hit(1'b0, 10'd2, 32'h0000_00FF);
    repeat (7) step();
    pop_chk("wrap_gt", 15'h7FFF, 2'd0, 1'b1);

    // Multi-hit: one start, six back-to-back stops, only four kept
    range = 15'd1000;
    hit(1'b1, 10'd0, 32'h0000_FFFF);
    for (int i = 1; i <= 6; i++) hit(1'b0, 10'(i), 32'h0000_FFFF);
    repeat (12) step();
    chk("multi_drop", drop, 0);
    chk("multi_busy", busy, 0);
    chk("multi_hold_data", tof_data, 32);
    step();
    chk("multi_hold_data2", tof_data, 32);
    for (int i = 0; i < 4; i++)
      pop_chk($sformatf("multi%0d", i), 15'(32 * (i + 1)), 2'(i), 1'b0);
    chk("multi_empty", out_valid, 0);

    // Fill the FIFO exactly
    hit(1'b1, 10'd0, 32'h0000_FFFF);
    for (int i = 10; i <= 13; i++) hit(1'b0, 10'(i), 32'h0000_FFFF);
    repeat (10) step();
    chk("full_valid", out_valid, 1);
    chk("full_no_drop", drop, 0);
    // One more result while full is lost
    hit(1'b1, 10'd0, 32'h0000_FFFF);
    hit(1'b0, 10'd20, 32'h0000_FFFF);
    repeat (10) step();
    chk("full_drop", drop, 1);
    chk("full_head", tof_data, 320);
    // Push and pop on the same edge while full
    hit(1'b1, 10'd0, 32'h0000_FFFF);
    hit(1'b0, 10'd3, 32'h0000_00FF);
    repeat (6) step();
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    pop_chk("pp0", 15'd352, 2'd1, 1'b0);
    pop_chk("pp1", 15'd384, 2'd2, 1'b0);
    pop_chk("pp2", 15'd416, 2'd3, 1'b0);
    pop_chk("pp3", 15'd104, 2'd0, 1'b0);
    chk("pp_empty", out_valid, 0);

    // Reset mid-shot with a result pending
    hit(1'b1, 10'd0, 32'h0000_FFFF);
    hit(1'b0, 10'd5, 32'h0000_FFFF);
    repeat (8) step();
    chk("pre_rst_data", tof_data, 160);
    hit(1'b0, 10'd6, 32'h0000_FFFF);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mid_rst_dec_valid", dec_valid, 0);
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_tof_data", tof_data, 0);
    chk("mid_rst_tof_idx", tof_idx, 0);
    chk("mid_rst_tof_ovr", tof_ovr, 0);
    chk("mid_rst_drop", drop, 0);
    chk("mid_rst_busy", busy, 0);
    // Stop without a new start is discarded
    hit(1'b0, 10'd7, 32'h0000_FFFF);
    repeat (3) step();
    chk("post_rst_dec3", dec_valid, 0);
    step();
    chk("post_rst_dec4", dec_valid, 1);
    repeat (6) step();
    chk("post_rst_out_valid", out_valid, 0);
    chk("post_rst_busy", busy, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
